// File: rtl/microgreen_pkg.sv
// Shared types and helpers for the OV7670 capture front end.
// Holds the camera FSM state enum, default counter widths and the RGB565 -> RGB888 expansion.
package microgreen_pkg;

  localparam int ROW_W_DEF = 9;
  localparam int COL_W_DEF = 10;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    FRAME_GAP,
    ACTIVE
  } cam_state_t;

  // Each channel's MSBs are replicated into its LSBs, so full scale maps to 0xFF.
  function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
    return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
  endfunction

endpackage

// File: rtl/ov7670_pixel_capture_if.sv
// Tagged pixel stream (valid/ready) leaving the capture block.
interface ov7670_pixel_capture_if #(
  parameter int ROW_W = 9,
  parameter int COL_W = 10
);
  logic             pix_valid;
  logic             pix_ready;
  logic [23:0]      pix_rgb;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;

  modport master (output pix_valid, pix_rgb, pix_row, pix_col, input pix_ready);
  modport slave  (input pix_valid, pix_rgb, pix_row, pix_col, output pix_ready);
endinterface

// File: rtl/pixcap_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted when a pop happens on the same cycle.
module pixcap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic             wr, rd;

  assign valid = (cnt != '0);
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign rd    = pop & valid;
  assign wr    = push & (~full | rd);
  // Hold the head at zero while empty so the stream is quiet out of reset.
  assign dout  = valid ? mem[rp] : '0;

  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture: oversampled camera port -> RGB888 pixels with row/col tags on a valid/ready FIFO.
// Define PIXCAP_CROP_EN to add an inclusive crop window (crop_x0/x1, crop_y0/y1).
module ov7670_pixel_capture
  import microgreen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ROW_W       = ROW_W_DEF,
  parameter int COL_W       = COL_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [7:0]            cam_d,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_pclk,
`ifdef PIXCAP_CROP_EN
  input  logic [COL_W-1:0]      crop_x0,
  input  logic [COL_W-1:0]      crop_x1,
  input  logic [ROW_W-1:0]      crop_y0,
  input  logic [ROW_W-1:0]      crop_y1,
`endif
  ov7670_pixel_capture_if.master pix,
  output logic                  frame_start,
  output logic                  frame_end,
  output logic                  line_end,
  output logic                  ovf,
  output logic                  odd_err
);
  localparam int PW = 24 + ROW_W + COL_W;

  logic [SYNC_STAGES-1:0]      pclk_sr, vs_sr, hr_sr;
  logic [SYNC_STAGES-1:0][7:0] d_sr;
  logic                        pclk_q, vs_q, hr_q;
  logic                        pclk_s, vs_s, hr_s;
  logic [7:0]                  d_s;

  cam_state_t       state, state_nxt;
  logic             phase, phase_n;
  logic [7:0]       hi, hi_n;
  logic [ROW_W-1:0] row, row_n;
  logic [COL_W-1:0] col, col_n;
  logic             ovf_n, odd_n;
  logic             armed, pix_evt, line_evt, frame_evt, end_evt;
  logic             push, pop, in_win, fifo_full;
  logic [23:0]      rgb_new;
  logic [PW-1:0]    fifo_dout;

  // Data rides an equal-depth delay line so it stays aligned with the synced pclk edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pclk_sr <= '0;
      vs_sr   <= '0;
      hr_sr   <= '0;
      d_sr    <= '0;
      pclk_q  <= 1'b0;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], cam_pclk};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], cam_vsync};
      hr_sr   <= {hr_sr[SYNC_STAGES-2:0], cam_href};
      d_sr    <= {d_sr[SYNC_STAGES-2:0], cam_d};
      pclk_q  <= pclk_s;
      vs_q    <= vs_s;
      hr_q    <= hr_s;
    end

  assign pclk_s = pclk_sr[SYNC_STAGES-1];
  assign vs_s   = vs_sr[SYNC_STAGES-1];
  assign hr_s   = hr_sr[SYNC_STAGES-1];
  assign d_s    = d_sr[SYNC_STAGES-1];

  assign armed     = (state == ACTIVE);
  assign pix_evt   = ena & armed & pclk_s & ~pclk_q & hr_s;
  assign line_evt  = ena & armed & ~hr_s & hr_q;
  assign frame_evt = ena & vs_s & ~vs_q;
  // The active region closes on the vsync edge that opens the next inter-frame gap.
  assign end_evt   = frame_evt & armed;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_FRAME;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (ena) begin
      if (vs_s & ~vs_q)                          state_nxt = FRAME_GAP;
      else if (~vs_s & vs_q && state == FRAME_GAP) state_nxt = ACTIVE;
    end
  end

`ifdef PIXCAP_CROP_EN
  assign in_win = (col >= crop_x0) && (col <= crop_x1) && (row >= crop_y0) && (row <= crop_y1);
`else
  assign in_win = 1'b1;
`endif

  assign rgb_new = rgb565_to_rgb888({hi, d_s});
  assign pop     = pix.pix_valid & pix.pix_ready;

  // Pixel handling precedes the line end so a coincident href fall sees the post-pixel phase.
  always_comb begin
    phase_n = phase;
    hi_n    = hi;
    row_n   = row;
    col_n   = col;
    ovf_n   = ovf;
    odd_n   = odd_err;
    push    = 1'b0;
    if (pix_evt) begin
      if (!phase) begin
        hi_n    = d_s;
        phase_n = 1'b1;
      end else begin
        push    = in_win;
        phase_n = 1'b0;
        if (col != '1) col_n = col + COL_W'(1);
      end
    end
    if (line_evt) begin
      if (phase_n) odd_n = 1'b1;
      phase_n = 1'b0;
      col_n   = '0;
      if (row != '1) row_n = row + ROW_W'(1);
    end
    if (push && fifo_full && !pop) ovf_n = 1'b1;
    if (frame_evt) begin
      row_n   = '0;
      col_n   = '0;
      phase_n = 1'b0;
      ovf_n   = 1'b0;
      odd_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase       <= 1'b0;
      hi          <= '0;
      row         <= '0;
      col         <= '0;
      ovf         <= 1'b0;
      odd_err     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      phase       <= phase_n;
      hi          <= hi_n;
      row         <= row_n;
      col         <= col_n;
      ovf         <= ovf_n;
      odd_err     <= odd_n;
      frame_start <= frame_evt;
      frame_end   <= end_evt;
      line_end    <= line_evt;
    end

  pixcap_fifo #(.WIDTH(PW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ({rgb_new, row, col}),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (pix.pix_valid),
    .full  (fifo_full)
  );

  assign {pix.pix_rgb, pix.pix_row, pix.pix_col} = fifo_dout;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture: reset, colour pairing, tags, events, overflow, odd lines, enable.
module tb_ov7670_pixel_capture;
  localparam int ROW_W = 9;
  localparam int COL_W = 10;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic [7:0] cam_d = 8'h00;
  logic       cam_vsync = 1'b0, cam_href = 1'b0, cam_pclk = 1'b0;
  logic       frame_start, frame_end, line_end, ovf, odd_err;
`ifdef PIXCAP_CROP_EN
  logic [COL_W-1:0] crop_x0 = '0, crop_x1 = '1;
  logic [ROW_W-1:0] crop_y0 = '0, crop_y1 = '1;
`endif

  int n_cmp = 0, n_bad = 0;
  int n_fs = 0, n_fe = 0, n_le = 0;
  logic [42:0] got_q[$];
  logic [7:0]  bq[$];

  ov7670_pixel_capture_if #(.ROW_W(ROW_W), .COL_W(COL_W)) pix();

  ov7670_pixel_capture #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .cam_d       (cam_d),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_pclk    (cam_pclk),
`ifdef PIXCAP_CROP_EN
    .crop_x0     (crop_x0),
    .crop_x1     (crop_x1),
    .crop_y0     (crop_y0),
    .crop_y1     (crop_y1),
`endif
    .pix         (pix),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_end    (line_end),
    .ovf         (ovf),
    .odd_err     (odd_err)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge, so the negedge view matches what the next edge uses.
  always @(negedge clk) begin
    if (pix.pix_valid && pix.pix_ready) got_q.push_back({pix.pix_rgb, pix.pix_row, pix.pix_col});
    if (frame_start) n_fs++;
    if (frame_end)   n_fe++;
    if (line_end)    n_le++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_pclk = 1'b0; cam_d = b; cyc(3);
    cam_pclk = 1'b1; cyc(3);
  endtask

  task automatic send_line();
    cam_href = 1'b1; cyc(2);
    while (bq.size() > 0) cam_byte(bq.pop_front());
    cam_pclk = 1'b0; cyc(3);
    cam_href = 1'b0; cyc(8);
  endtask

  task automatic vs_pulse();
    cam_vsync = 1'b1; cyc(8);
    cam_vsync = 1'b0; cyc(8);
  endtask

  function automatic logic [23:0] ref_rgb(input logic [7:0] hi, input logic [7:0] lo);
    logic [7:0] r, g, b;
    r = {3'b0, hi[7:3]};
    g = {2'b0, hi[2:0], lo[7:5]};
    b = {3'b0, lo[4:0]};
    return {(r << 3) | (r >> 2), (g << 2) | (g >> 4), (b << 3) | (b >> 2)};
  endfunction

  task automatic expect_raw(input string tag, input logic [23:0] rgb, input int row, input int col);
    logic [42:0] got;
    got = (got_q.size() > 0) ? got_q.pop_front() : 'x;
    chk(tag, 64'(got), {21'd0, rgb, 9'(row), 10'(col)});
  endtask

  task automatic expect_pix(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                            input int row, input int col);
    expect_raw(tag, ref_rgb(hi, lo), row, col);
  endtask

  initial begin
    pix.pix_ready = 1'b1;
    cyc(4);
    chk("rst_valid", 64'(pix.pix_valid), 64'd0);
    chk("rst_rgb",   64'(pix.pix_rgb),   64'd0);
    chk("rst_flags", 64'({frame_start, frame_end, line_end, ovf, odd_err}), 64'd0);
    rst_n = 1'b1; ena = 1'b1; cyc(4);

    // Reset in the middle of a line: nothing may come out until a full vsync cycle.
    vs_pulse();
    cam_href = 1'b1; cyc(2);
    cam_byte(8'h55);
    rst_n = 1'b0; cyc(2);
    chk("midrst_flags", 64'({pix.pix_valid, ovf, odd_err, line_end}), 64'd0);
    rst_n = 1'b1;
    cam_byte(8'h66); cam_byte(8'h77); cam_byte(8'h88);
    cam_pclk = 1'b0; cyc(3); cam_href = 1'b0; cyc(8);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04}; send_line();
    chk("pre_frame_pix", 64'(got_q.size()), 64'd0);
    chk("pre_frame_le",  64'(n_le), 64'd0);

    // 2x2 frame with the four reference colours.
    got_q.delete(); n_fs = 0; n_fe = 0; n_le = 0;
    vs_pulse();
    bq = '{8'hF8, 8'h00, 8'h07, 8'hE0}; send_line();
    bq = '{8'h00, 8'h1F, 8'hFF, 8'hFF}; send_line();
    vs_pulse();
    chk("f1_count", 64'(got_q.size()), 64'd4);
    expect_raw("f1_red",   24'hFF0000, 0, 0);
    expect_raw("f1_green", 24'h00FF00, 0, 1);
    expect_raw("f1_blue",  24'h0000FF, 1, 0);
    expect_raw("f1_white", 24'hFFFFFF, 1, 1);
    chk("f1_line_end",    64'(n_le), 64'd2);
    chk("f1_frame_end",   64'(n_fe), 64'd1);
    chk("f1_frame_start", 64'(n_fs), 64'd2);

    // 3 lines x 4 pixels: tags in order.
    got_q.delete(); n_fs = 0; n_fe = 0; n_le = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        bq.push_back(8'(r * 16 + c));
        bq.push_back(8'(8'hA5 ^ (r * 4 + c)));
      end
      send_line();
    end
    vs_pulse();
    chk("f2_count", 64'(got_q.size()), 64'd12);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        expect_pix("f2_pix", 8'(r * 16 + c), 8'(8'hA5 ^ (r * 4 + c)), r, c);
    chk("f2_line_end",  64'(n_le), 64'd3);
    chk("f2_frame_end", 64'(n_fe), 64'd1);

    // Six pixels into a 4-deep FIFO with the sink stalled.
    got_q.delete();
    pix.pix_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bq.push_back(8'(8'h80 + k * 8));
      bq.push_back(8'(8'h20 + k));
    end
    send_line();
    chk("ovf_set",  64'(ovf), 64'd1);
    chk("ovf_head", 64'(pix.pix_rgb), 64'(ref_rgb(8'h80, 8'h20)));
    pix.pix_ready = 1'b1;
    cyc(10);
    chk("ovf_kept", 64'(got_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      expect_pix("ovf_order", 8'(8'h80 + k * 8), 8'(8'h20 + k), 0, k);
    chk("ovf_sticky", 64'(ovf), 64'd1);
    vs_pulse();
    chk("ovf_clear", 64'(ovf), 64'd0);

    // Odd byte count: trailing byte dropped, next line realigned.
    got_q.delete();
    bq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5}; send_line();
    chk("odd_set", 64'(odd_err), 64'd1);
    bq = '{8'h12, 8'h34, 8'h56, 8'h78}; send_line();
    chk("odd_count", 64'(got_q.size()), 64'd4);
    expect_pix("odd_p0", 8'hA1, 8'hB2, 0, 0);
    expect_pix("odd_p1", 8'hC3, 8'hD4, 0, 1);
    expect_pix("odd_p2", 8'h12, 8'h34, 1, 0);
    expect_pix("odd_p3", 8'h56, 8'h78, 1, 1);
    chk("odd_sticky", 64'(odd_err), 64'd1);
    vs_pulse();
    chk("odd_clear", 64'(odd_err), 64'd0);

    // Disabled line is ignored entirely; counters stay put.
    got_q.delete(); n_le = 0;
    ena = 1'b0;
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; send_line();
    ena = 1'b1;
    bq = '{8'hF8, 8'h00}; send_line();
    chk("ena_count", 64'(got_q.size()), 64'd1);
    expect_raw("ena_pix", 24'hFF0000, 0, 0);
    chk("ena_line_end", 64'(n_le), 64'd1);

`ifdef PIXCAP_CROP_EN
    crop_x0 = 10'd1; crop_x1 = 10'd2; crop_y0 = 9'd1; crop_y1 = 9'd1;
    vs_pulse();
    got_q.delete();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        bq.push_back(8'(r * 16 + c));
        bq.push_back(8'(8'h3C + c));
      end
      send_line();
    end
    chk("crop_count", 64'(got_q.size()), 64'd2);
    expect_pix("crop_p0", 8'h11, 8'h3D, 1, 1);
    expect_pix("crop_p1", 8'h12, 8'h3E, 1, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
